// File: rtl/seg_approx_mult_if.sv
// Operand/result bundle for the dynamic-segment approximate multiplier.
// The master drives start and operands, the slave returns status and result.
interface seg_approx_mult_if #(
    parameter int W = 16
) ();
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           exact;

    modport master (
        output start, a, b,
        input  busy, done, product, exact
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, exact
    );
endinterface

// File: rtl/seg_approx_mult.sv
// Sequential dynamic-segment approximate multiplier (leading-one normalize, KxK multiply).
// Optional build macro SEG_ROUND_EN: forces segment LSB to 1 when lower bits were discarded.
module seg_approx_mult #(
    parameter int W = 16,
    parameter int K = 8
) (
    input  logic              clk,
    input  logic              rst,
    seg_approx_mult_if.slave  bus
);
    localparam int CW  = (W - K + 1) > 1 ? $clog2(W - K + 1) : 1;
    localparam int SHW = CW + 1;
    localparam int PW  = 2 * W;

    localparam logic [CW-1:0]  CMAX     = CW'(W - K);
    localparam logic [CW-1:0]  C_ONE    = CW'(1);
    localparam logic [SHW-1:0] SH_BASE  = SHW'(2 * (W - K));
    localparam logic [W-1:0]   ONE_W    = W'(1);
    localparam logic [W-1:0]   LOW_MASK = (ONE_W << (W - K)) - ONE_W;

    typedef enum logic [1:0] {IDLE, NORM, MULT} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   rega_q, rega_d;
    logic [W-1:0]   regb_q, regb_d;
    logic [CW-1:0]  ca_q, ca_d;
    logic [CW-1:0]  cb_q, cb_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [PW-1:0]  product_q, product_d;
    logic           exact_q, exact_d;

    logic           norm_a, norm_b;
    logic           da, db;
    logic [K-1:0]   sega, segb;
    logic [2*K-1:0] mul;
    logic [SHW-1:0] sh;

    // Segment extraction, discard flags and the scaled KxK product.
    always_comb begin
        norm_a = rega_q[W-1] | (ca_q == CMAX);
        norm_b = regb_q[W-1] | (cb_q == CMAX);
        da     = |(rega_q & LOW_MASK);
        db     = |(regb_q & LOW_MASK);
        sega   = rega_q[W-1 -: K];
        segb   = regb_q[W-1 -: K];
`ifdef SEG_ROUND_EN
        sega[0] = sega[0] | da;
        segb[0] = segb[0] | db;
`endif
        mul = {{K{1'b0}}, sega} * {{K{1'b0}}, segb};
        sh  = SH_BASE - {1'b0, ca_q} - {1'b0, cb_q};
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_d   = state_q;
        rega_d    = rega_q;
        regb_d    = regb_q;
        ca_d      = ca_q;
        cb_d      = cb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        exact_d   = exact_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rega_d  = bus.a;
                    regb_d  = bus.b;
                    ca_d    = '0;
                    cb_d    = '0;
                    busy_d  = 1'b1;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (norm_a && norm_b) begin
                    state_d = MULT;
                end else begin
                    if (!norm_a) begin
                        rega_d = rega_q << 1;
                        ca_d   = ca_q + C_ONE;
                    end
                    if (!norm_b) begin
                        regb_d = regb_q << 1;
                        cb_d   = cb_q + C_ONE;
                    end
                end
            end
            MULT: begin
                product_d = PW'(mul) << sh;
                exact_d   = ~(da | db);
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rega_q    <= '0;
            regb_q    <= '0;
            ca_q      <= '0;
            cb_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            exact_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rega_q    <= rega_d;
            regb_q    <= regb_d;
            ca_q      <= ca_d;
            cb_q      <= cb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
            exact_q   <= exact_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.exact   = exact_q;
endmodule

// File: tb/tb_seg_approx_mult.sv
// Scoreboard bench for seg_approx_mult: W=16/K=8 and W=8/K=8 instances.
// Expected results are queued at issue time and checked when done pulses.
module tb_seg_approx_mult;
    typedef struct {
        logic [31:0] p;
        logic        x;
        int          e;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   dones16 = 0;
    exp_t q16[$];
    exp_t q8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_approx_mult_if #(.W(16)) if16 ();
    seg_approx_mult_if #(.W(8))  if8 ();

    seg_approx_mult #(.W(16), .K(8)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    seg_approx_mult #(.W(8), .K(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (if16.done === 1'b1) begin
            exp_t e;
            dones16++;
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done16 actual=1 required=0 t=%0t", $time);
            end else begin
                e = q16.pop_front();
                check("product16", 64'(if16.product), 64'(e.p));
                check("exact16", 64'(if16.exact), 64'(e.x));
                check("latency16", 64'(cyc), 64'(e.e));
                check("busy_at_done16", 64'(if16.busy), 64'(0));
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (if8.done === 1'b1) begin
            exp_t e;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8 actual=1 required=0 t=%0t", $time);
            end else begin
                e = q8.pop_front();
                check("product8", 64'(if8.product), 64'(e.p));
                check("exact8", 64'(if8.exact), 64'(e.x));
                check("latency8", 64'(cyc), 64'(e.e));
            end
        end
    end

    task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] p, input logic x, input int lat);
        exp_t e;
        @(negedge clk);
        if16.start = 1'b1;
        if16.a     = a;
        if16.b     = b;
        e.p = p;
        e.x = x;
        e.e = cyc + 1 + lat;
        q16.push_back(e);
        @(negedge clk);
        if16.start = 1'b0;
        check("busy16", 64'(if16.busy), 64'(1));
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] p, input logic x, input int lat);
        exp_t e;
        @(negedge clk);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        e.p = 32'(p);
        e.x = x;
        e.e = cyc + 1 + lat;
        q8.push_back(e);
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q16.size() != 0 || q8.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q16.size() != 0 || q8.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending16=%0d pending8=%0d required=0",
                     q16.size(), q8.size());
            q16.delete();
            q8.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int s;
        int n;
        int d0;
        logic [31:0] p3;
        rst       = 1'b1;
        if16.start = 1'b0;
        if16.a     = '0;
        if16.b     = '0;
        if8.start  = 1'b0;
        if8.a      = '0;
        if8.b      = '0;
        repeat (2) @(negedge clk);
        check("rst_busy16", 64'(if16.busy), 64'(0));
        check("rst_done16", 64'(if16.done), 64'(0));
        check("rst_product16", 64'(if16.product), 64'(0));
        check("rst_exact16", 64'(if16.exact), 64'(0));
        check("rst_product8", 64'(if8.product), 64'(0));
        rst = 1'b0;

        issue16(16'h00FF, 16'h0003, 32'h000002FD, 1'b1, 10);
        drain();
        issue16(16'hFFFF, 16'hFFFF, 32'hFE010000, 1'b0, 2);
        drain();
`ifdef SEG_ROUND_EN
        p3 = 32'h00102000;
`else
        p3 = 32'h00100000;
`endif
        issue16(16'h1004, 16'h0100, p3, 1'b0, 9);
        drain();
        issue16(16'h8000, 16'h0001, 32'h00008000, 1'b1, 10);
        drain();
        issue16(16'h0000, 16'hFFFF, 32'h00000000, 1'b0, 10);
        drain();

        // Start ignored while busy, then back-to-back start in the done cycle.
        issue16(16'h0000, 16'h0000, 32'h00000000, 1'b1, 10);
        if16.start = 1'b1;
        if16.a     = 16'hFFFF;
        if16.b     = 16'hFFFF;
        @(negedge clk);
        if16.start = 1'b0;
        n = 0;
        while (if16.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen16", 64'(if16.done), 64'(1));
        begin
            exp_t e;
            if16.start = 1'b1;
            if16.a     = 16'h8000;
            if16.b     = 16'h8000;
            e.p = 32'h40000000;
            e.x = 1'b1;
            e.e = cyc + 1 + 2;
            q16.push_back(e);
        end
        @(negedge clk);
        if16.start = 1'b0;
        drain();

        // Reset mid-NORM drops the operation.
        @(negedge clk);
        if16.start = 1'b1;
        if16.a     = 16'h0001;
        if16.b     = 16'h0001;
        s = cyc + 1;
        @(negedge clk);
        if16.start = 1'b0;
        while (cyc < s + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy16", 64'(if16.busy), 64'(0));
        check("midrst_done16", 64'(if16.done), 64'(0));
        check("midrst_product16", 64'(if16.product), 64'(0));
        check("midrst_exact16", 64'(if16.exact), 64'(0));
        d0 = dones16;
        repeat (20) @(negedge clk);
        check("no_done_after_rst16", 64'(dones16 - d0), 64'(0));

        issue8(8'hC3, 8'h05, 16'h03CF, 1'b1, 2);
        drain();
        issue8(8'h00, 8'h7F, 16'h0000, 1'b1, 2);
        drain();
        issue8(8'hFF, 8'hFF, 16'hFE01, 1'b1, 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
